add_seq_ctrl: RTL and testbench
===============================

ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 Parameter: SETTLE_CYCLES, 3, cycles each 16-bit slice is held on the shared adder before capture (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a 64-bit addition; accepted only when busy=0.
REQ-005 op_a  input  64  operand A, sampled on accepted start.
REQ-006 op_b  input  64  operand B, sampled on accepted start.
REQ-007 cin  input  1  carry-in, sampled on accepted start.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle pulse; result/cout valid in that cycle.
REQ-010 result  output  64  registered sum; holds until next done.
REQ-011 cout  output  1  registered carry-out of bit 63; holds until next done.
REQ-012 add_a  output  16  operand A slice to the shared rc_adder16.
REQ-013 add_b  output  16  operand B slice to the shared rc_adder16.
REQ-014 add_cin  output  1  carry-in to the shared adder.
REQ-015 add_sum  input  16  sum from the shared adder.
REQ-016 add_cout  input  1  carry-out from the shared adder.

Function
REQ-017 FSM states SHALL be IDLE, SETTLE, DONE; IDLE->SETTLE on start=1; SETTLE->DONE after slice 3 captured; DONE->IDLE unconditionally.
REQ-018 On accepted start: latch op_a, op_b; carry register := cin; slice index := 0; settle counter := 0.
REQ-019 In SETTLE: add_a/add_b SHALL be bits [16*idx+15:16*idx] of latched operands; add_cin SHALL be the carry register.
REQ-020 In SETTLE the counter increments each cycle; when counter = SETTLE_CYCLES-1: add_sum written to accumulator slice idx, add_cout to carry register, counter := 0, idx := idx+1 (or go DONE if idx=3).
REQ-021 In IDLE and DONE, add_a, add_b, add_cin SHALL be 0.
REQ-022 In DONE: result := accumulator, cout := carry register, done = 1 for exactly one cycle.
REQ-023 Latency: done SHALL assert exactly 4*SETTLE_CYCLES+1 cycles after the edge that accepts start (13 for default).
REQ-024 start while busy=1 (including DONE cycle) SHALL be ignored with no effect on latched operands.
REQ-025 Back-to-back: start asserted the cycle after done SHALL be accepted.
REQ-026 Arithmetic is unsigned mod 2^64; carry SHALL ripple slice-to-slice only through the carry register.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, result=0, cout=0, idx=0, counter=0, carry register=0, regardless of state.
REQ-028 Reset mid-operation SHALL abandon the addition; no done pulse SHALL follow.
REQ-029 start asserted together with rst SHALL be ignored.

Configuration
REQ-030 Macro ADD_SEQ_CTRL_OVF_EN: when defined, output port ovf (1 bit) SHALL exist, registered in DONE as (a63 XOR b63 XOR s63) XOR cout, reset to 0, holding until next done.
REQ-031 Without ADD_SEQ_CTRL_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour identical.

Verification (SETTLE_CYCLES=3, adder model rc_adder16)
REQ-032 op_a=10, op_b=22, cin=0 -> done 13 cycles after start, result=32, cout=0.
REQ-033 op_a=0xFFFFFFFFFFFFFFFF, op_b=1, cin=0 -> result=0, cout=1, ovf=0.
REQ-034 op_a=0x7FFFFFFFFFFFFFFF, op_b=0, cin=1 -> result=0x8000000000000000, cout=0, ovf=1.
REQ-035 op_a=0x0000FFFF0000FFFF, op_b=1 -> result=0x0000FFFF00010000 (inter-slice carry); add_cin=1 observed only during slice 1.
REQ-036 start re-pulsed with op_a=5 during busy -> ignored, first result delivered; start the cycle after done accepted, second done 13 cycles later.
REQ-037 rst asserted during slice 2 -> next cycle busy=0, result=0, no done; subsequent 10+22 yields 32.

Source files
------------

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: 64-bit add sequenced as four 16-bit slices through one shared external adder.
// Define ADD_SEQ_CTRL_OVF_EN to add the signed-overflow output ovf.
module add_seq_ctrl #(
  parameter int SETTLE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  input  logic        cin,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic        cout,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [15:0] add_sum,
  input  logic        add_cout
`ifdef ADD_SEQ_CTRL_OVF_EN
  ,
  output logic        ovf
`endif
);
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
  state_t      state_q;
  logic [63:0] a_q, b_q, result_q;
  logic [47:0] acc_q;
  logic        carry_q, cout_q;
  logic [1:0]  idx_q;
  logic [3:0]  cnt_q;
  logic        settle, last;
`ifdef ADD_SEQ_CTRL_OVF_EN
  logic        ovf_q;
  assign ovf = ovf_q;
`endif
  assign settle  = state_q == SETTLE;
  assign last    = cnt_q == 4'(SETTLE_CYCLES - 1);
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;
  assign result  = result_q;
  assign cout    = cout_q;
  assign add_a   = settle ? a_q[{idx_q, 4'b0} +: 16] : '0;
  assign add_b   = settle ? b_q[{idx_q, 4'b0} +: 16] : '0;
  assign add_cin = settle & carry_q;
  // Slices 0..2 shift in from the top so they land in order; slice 3 goes straight to result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
`ifdef ADD_SEQ_CTRL_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= SETTLE;
          a_q     <= op_a;
          b_q     <= op_b;
          carry_q <= cin;
          idx_q   <= '0;
          cnt_q   <= '0;
        end
        SETTLE: if (last) begin
          cnt_q   <= '0;
          carry_q <= add_cout;
          if (idx_q == 2'd3) begin
            state_q  <= DONE;
            result_q <= {add_sum, acc_q};
            cout_q   <= add_cout;
`ifdef ADD_SEQ_CTRL_OVF_EN
            ovf_q    <= a_q[63] ^ b_q[63] ^ add_sum[15] ^ add_cout;
`endif
          end else begin
            acc_q <= {add_sum, acc_q[47:16]};
            idx_q <= idx_q + 2'd1;
          end
        end else cnt_q <= cnt_q + 4'd1;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: directed checks of add_seq_ctrl driving a behavioural 16-bit ripple adder.
module tb_add_seq_ctrl;
  logic        clk = 0, rst = 1, start = 0, cin = 0;
  logic [63:0] op_a = 0, op_b = 0, result;
  logic        busy, done, cout, add_cin, add_cout;
  logic [15:0] add_a, add_b, add_sum;
  logic        ovf_obs;
  int          n_chk = 0, n_fail = 0;
  int          n, cnt;
  logic [3:0]  mask;
  always #5 clk = ~clk;
  assign {add_cout, add_sum} = 17'(add_a) + 17'(add_b) + 17'(add_cin);
`ifdef ADD_SEQ_CTRL_OVF_EN
  logic ovf;
  assign ovf_obs = ovf;
`else
  assign ovf_obs = 1'b0;
`endif
  add_seq_ctrl #(.SETTLE_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
`ifdef ADD_SEQ_CTRL_OVF_EN
    , .ovf(ovf)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // n counts negedges after the accepting edge (first one is 1); slice = (n-1)/3 while settling.
  task automatic wait_done(input int n0, output int nd, output logic [3:0] m);
    nd = n0;
    m  = '0;
    while (!done && nd < 40) begin
      if (add_cin) m[(nd - 1) / 3] = 1'b1;
      @(negedge clk);
      nd++;
    end
  endtask
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic c,
                        input logic [63:0] er, input logic ec, input logic eo, input logic [3:0] em);
    int nd;
    logic [3:0] m;
    @(negedge clk);
    op_a = a; op_b = b; cin = c; start = 1;
    @(negedge clk);
    start = 0;
    chk("busy_after_start", 64'(busy), 64'd1);
    wait_done(1, nd, m);
    chk("latency", 64'(nd), 64'd13);
    chk("result", result, er);
    chk("cout", 64'(cout), 64'(ec));
    chk("carry_slices", 64'(m), 64'(em));
    chk("done_add_a_zero", 64'({add_a, add_b, add_cin}), 64'd0);
`ifdef ADD_SEQ_CTRL_OVF_EN
    chk("ovf", 64'(ovf_obs), 64'(eo));
`endif
    @(negedge clk);
    chk("done_one_cycle", 64'({done, busy}), 64'd0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_busy_done", 64'({busy, done}), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_cout_ovf", 64'({cout, ovf_obs}), 64'd0);
    chk("idle_adder_in", 64'({add_a, add_b, add_cin}), 64'd0);
    run_op(64'd10, 64'd22, 1'b0, 64'd32, 1'b0, 1'b0, 4'b0000);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 4'b1110);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 4'b1111);
    run_op(64'h0000_FFFF_0000_FFFF, 64'd1, 1'b0, 64'h0000_FFFF_0001_0000, 1'b0, 1'b0, 4'b0010);
    // start pulses while busy and in the done cycle are ignored; the cycle after done is accepted
    @(negedge clk);
    op_a = 64'd10; op_b = 64'd22; cin = 0; start = 1;
    @(negedge clk);
    start = 0;
    chk("slice0_add_a", 64'(add_a), 64'd10);
    repeat (3) @(negedge clk);
    op_a = 64'd5; start = 1;
    @(negedge clk);
    start = 0;
    wait_done(5, n, mask);
    chk("busy_start_lat", 64'(n), 64'd13);
    chk("busy_start_result", result, 64'd32);
    op_a = 64'd5; op_b = 64'd0; start = 1;
    @(negedge clk);
    chk("done_start_ignored", 64'(busy), 64'd0);
    chk("result_holds", result, 64'd32);
    op_a = 64'd100; op_b = 64'd23;
    @(negedge clk);
    start = 0;
    chk("b2b_accepted", 64'(busy), 64'd1);
    wait_done(1, n, mask);
    chk("b2b_latency", 64'(n), 64'd13);
    chk("b2b_result", result, 64'd123);
    // reset during slice 2
    @(negedge clk);
    op_a = 64'd10; op_b = 64'd22; cin = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (6) @(negedge clk);
    chk("slice2_active", 64'(busy), 64'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_busy_done", 64'({busy, done}), 64'd0);
    chk("midrst_result", result, 64'd0);
    chk("midrst_cout", 64'(cout), 64'd0);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("midrst_no_done", 64'(cnt), 64'd0);
    run_op(64'd10, 64'd22, 1'b0, 64'd32, 1'b0, 1'b0, 4'b0000);
    // start together with reset
    @(negedge clk);
    op_a = 64'd1; op_b = 64'd1; rst = 1; start = 1;
    @(negedge clk);
    rst = 0; start = 0;
    chk("rst_start_ignored", 64'(busy), 64'd0);
    @(negedge clk);
    chk("rst_start_still_idle", 64'({busy, done}), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
